// File: rtl/pid_pkg.sv
// Shared widths and the saturation helper for the PID controller datapath.
package pid_pkg;

  // Default sample width and the derived widths it implies.
  localparam int PID_DW = 14;
  localparam int OW     = 2 * PID_DW + 1;
  localparam int ERR_W  = PID_DW + 1;
  localparam int DIFF_W = PID_DW + 2;

  // Container width for intermediate products and sums before clamping.
  localparam int WIDE_W = 64;

  // Derived widths for an arbitrary sample width.
  function automatic int out_w(input int dw);
    return 2 * dw + 1;
  endfunction

  function automatic int err_w(input int dw);
    return dw + 1;
  endfunction

  function automatic int diff_w(input int dw);
    return dw + 2;
  endfunction

  // Clamp a value of width iw, already sign-extended into the wide container,
  // to the signed range of an ow-bit result. Callers take the low ow bits.
  function automatic logic signed [WIDE_W-1:0] sat_wide(
    input logic signed [WIDE_W-1:0] x,
    input int unsigned              iw,
    input int unsigned              ow
  );
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (iw <= ow)   return x;
    else if (x > hi) return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/pid_sat_acc.sv
// Saturating signed integrator: clamps at either rail, never wraps.
module pid_sat_acc
  import pid_pkg::*;
#(
  parameter int OW = pid_pkg::OW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [OW-1:0] increment,
  output logic signed [OW-1:0] acc
);

  logic signed [OW-1:0]     acc_q = '0;
  logic signed [OW-1:0]     acc_d;
  logic signed [WIDE_W-1:0] sum_wide;

  // Next accumulator value: one-bit-wider sum clamped back to OW bits.
  always_comb begin
    sum_wide = WIDE_W'(acc_q) + WIDE_W'(increment);
    acc_d    = OW'(sat_wide(sum_wide, OW + 1, OW));
  end

  // Accumulator register; reset discards all integral history.
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/pid_controller_core.sv
// Three-stage pipelined fixed-point PID controller with saturated output.
module pid_controller_core
  import pid_pkg::*;
#(
  parameter int DATA_WIDTH = 14
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [DATA_WIDTH-1:0]   data_in,
  input  logic signed [DATA_WIDTH-1:0]   set_point,
  input  logic signed [DATA_WIDTH-1:0]   p_coef,
  input  logic signed [DATA_WIDTH-1:0]   i_coef,
  input  logic signed [DATA_WIDTH-1:0]   d_coef,
  output logic signed [2*DATA_WIDTH:0]   data_out
);

  localparam int O_W  = out_w(DATA_WIDTH);
  localparam int E_W  = err_w(DATA_WIDTH);
  localparam int DF_W = diff_w(DATA_WIDTH);
  localparam int S_W  = O_W + 2;

  // Stage 1 state: error, previous error, gain copies.
  logic signed [E_W-1:0]        err_p1_q = '0;
  logic signed [E_W-1:0]        err_prev_p1_q = '0;
  logic signed [DATA_WIDTH-1:0] p_c_p1_q = '0;
  logic signed [DATA_WIDTH-1:0] i_c_p1_q = '0;
  logic signed [DATA_WIDTH-1:0] d_c_p1_q = '0;
  logic signed [E_W-1:0]        err_p1_d;

  // Stage 2 state: P and D terms (integrator lives in pid_sat_acc).
  logic signed [O_W-1:0]        p_term_p2_q = '0;
  logic signed [O_W-1:0]        d_term_p2_q = '0;
  logic signed [O_W-1:0]        p_term_p2_d;
  logic signed [O_W-1:0]        d_term_p2_d;
  logic signed [O_W-1:0]        i_inc_p2;
  logic signed [O_W-1:0]        integ_p2;
  logic signed [DF_W-1:0]       diff_p2;

  // Stage 3 state: saturated control word.
  logic signed [O_W-1:0]        data_out_p3_q = '0;
  logic signed [O_W-1:0]        data_out_p3_d;
  logic signed [S_W-1:0]        sum_p3;

  // Error formed one bit wider than the inputs so it can never overflow.
  always_comb begin
    err_p1_d = E_W'(set_point) - E_W'(data_in);
  end

  // Stage 1 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_p1_q      <= '0;
      err_prev_p1_q <= '0;
      p_c_p1_q      <= '0;
      i_c_p1_q      <= '0;
      d_c_p1_q      <= '0;
    end else begin
      err_p1_q      <= err_p1_d;
      err_prev_p1_q <= err_p1_q;
      p_c_p1_q      <= p_coef;
      i_c_p1_q      <= i_coef;
      d_c_p1_q      <= d_coef;
    end
  end

  // Term products: P fits exactly in O_W bits; D is one bit wider and clamped.
  always_comb begin
    p_term_p2_d = O_W'(WIDE_W'(p_c_p1_q) * WIDE_W'(err_p1_q));
    diff_p2     = DF_W'(err_p1_q) - DF_W'(err_prev_p1_q);
    d_term_p2_d = O_W'(sat_wide(WIDE_W'(d_c_p1_q) * WIDE_W'(diff_p2),
                                DATA_WIDTH + DF_W, O_W));
    i_inc_p2    = O_W'(WIDE_W'(i_c_p1_q) * WIDE_W'(err_p1_q));
  end

  // Stage 2 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_term_p2_q <= '0;
      d_term_p2_q <= '0;
    end else begin
      p_term_p2_q <= p_term_p2_d;
      d_term_p2_q <= d_term_p2_d;
    end
  end

  pid_sat_acc #(
    .OW (O_W)
  ) u_integ (
    .clk       (clk),
    .rst       (rst),
    .increment (i_inc_p2),
    .acc       (integ_p2)
  );

  // Three-term sum carried two bits wide, then clamped to the output range.
  always_comb begin
    sum_p3        = S_W'(p_term_p2_q) + S_W'(d_term_p2_q) + S_W'(integ_p2);
    data_out_p3_d = O_W'(sat_wide(WIDE_W'(sum_p3), S_W, O_W));
  end

  // Stage 3 register.
  always_ff @(posedge clk) begin
    if (rst) data_out_p3_q <= '0;
    else     data_out_p3_q <= data_out_p3_d;
  end

  assign data_out = data_out_p3_q;

endmodule

// File: tb/tb_pid_controller_core.sv
// Directed-vector bench for pid_controller_core (DATA_WIDTH = 14).
module tb_pid_controller_core;

  localparam int DW = 14;
  localparam int OWB = 2 * DW + 1;

  logic                  clk;
  logic                  rst;
  logic signed [DW-1:0]  data_in;
  logic signed [DW-1:0]  set_point;
  logic signed [DW-1:0]  p_coef;
  logic signed [DW-1:0]  i_coef;
  logic signed [DW-1:0]  d_coef;
  logic signed [OWB-1:0] data_out;

  int n_checks;
  int n_errors;

  typedef struct {
    logic   r;
    int     di;
    int     sp;
    int     p;
    int     i;
    int     d;
    longint exp;
    string  name;
  } vec_t;

  vec_t vecs[$];

  pid_controller_core #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .set_point (set_point),
    .p_coef    (p_coef),
    .i_coef    (i_coef),
    .d_coef    (d_coef),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, int di, int sp, int p, int i, int d,
                              longint exp, string name);
    vec_t v;
    v.r = r; v.di = di; v.sp = sp; v.p = p; v.i = i; v.d = d;
    v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic drive(input logic r, input int di, input int sp,
                       input int p, input int i, input int d);
    rst       = r;
    data_in   = DW'(di);
    set_point = DW'(sp);
    p_coef    = DW'(p);
    i_coef    = DW'(i);
    d_coef    = DW'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint exp);
    longint act;
    act = longint'(data_out);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: data_out=%0d expected=%0d", name, act, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive(1'b1, 0, 0, 0, 0, 0);

    // Step from reset, held reset, gain change at edge 7, mid-run reset at edge 11.
    vecs.push_back(mk(1, 2048, 4096, 4096, 1, 1, 0, "rst_hold0"));
    vecs.push_back(mk(1, 2048, 4096, 4096, 1, 1, 0, "rst_hold1"));
    vecs.push_back(mk(0, 2048, 4096, 4096, 1, 1, 0, "step_e1"));
    vecs.push_back(mk(0, 2048, 4096, 4096, 1, 1, 0, "step_e2"));
    vecs.push_back(mk(0, 2048, 4096, 4096, 1, 1, 8392704, "step_e3"));
    vecs.push_back(mk(0, 2048, 4096, 4096, 1, 1, 8392704, "step_e4"));
    vecs.push_back(mk(0, 2048, 4096, 4096, 1, 1, 8394752, "step_e5"));
    vecs.push_back(mk(0, 2048, 4096, 4096, 1, 1, 8396800, "step_e6"));
    vecs.push_back(mk(0, 2048, 4096, 128, 1, 1, 8398848, "gain_e7"));
    vecs.push_back(mk(0, 2048, 4096, 128, 1, 1, 8400896, "gain_e8"));
    vecs.push_back(mk(0, 2048, 4096, 128, 1, 1, 276480, "gain_e9"));
    vecs.push_back(mk(0, 2048, 4096, 128, 1, 1, 278528, "gain_e10"));
    vecs.push_back(mk(1, 2048, 4096, 4096, 1, 1, 0, "midrst"));
    vecs.push_back(mk(0, 2048, 4096, 4096, 1, 1, 0, "restart_e1"));
    vecs.push_back(mk(0, 2048, 4096, 4096, 1, 1, 0, "restart_e2"));
    vecs.push_back(mk(0, 2048, 4096, 4096, 1, 1, 8392704, "restart_e3"));
    vecs.push_back(mk(0, 2048, 4096, 4096, 1, 1, 8392704, "restart_e4"));
    vecs.push_back(mk(0, 2048, 4096, 4096, 1, 1, 8394752, "restart_e5"));

    // Derivative pulse: error step of +10 with d=100.
    vecs.push_back(mk(1, 0, 0, 0, 0, 100, 0, "der_rst"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 100, 0, "der_idle0"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 100, 0, "der_idle1"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 100, 0, "der_idle2"));
    vecs.push_back(mk(0, -10, 0, 0, 0, 100, 0, "der_s1"));
    vecs.push_back(mk(0, -10, 0, 0, 0, 100, 0, "der_s2"));
    vecs.push_back(mk(0, -10, 0, 0, 0, 100, 1000, "der_pulse"));
    vecs.push_back(mk(0, -10, 0, 0, 0, 100, 0, "der_after0"));
    vecs.push_back(mk(0, -10, 0, 0, 0, 100, 0, "der_after1"));

    // Integrator clamp at the positive rail, then release with negated error.
    vecs.push_back(mk(1, -8192, 8191, 0, 8191, 0, 0, "isat_rst"));
    vecs.push_back(mk(0, -8192, 8191, 0, 8191, 0, 0, "isat_e1"));
    vecs.push_back(mk(0, -8192, 8191, 0, 8191, 0, 0, "isat_e2"));
    vecs.push_back(mk(0, -8192, 8191, 0, 8191, 0, 134193153, "isat_e3"));
    vecs.push_back(mk(0, -8192, 8191, 0, 8191, 0, 268386306, "isat_e4"));
    vecs.push_back(mk(0, -8192, 8191, 0, 8191, 0, 268435455, "isat_clamp"));
    vecs.push_back(mk(0, -8192, 8191, 0, 8191, 0, 268435455, "isat_hold"));
    vecs.push_back(mk(0, 8191, -8192, 0, 8191, 0, 268435455, "isat_neg_e1"));
    vecs.push_back(mk(0, 8191, -8192, 0, 8191, 0, 268435455, "isat_neg_e2"));
    vecs.push_back(mk(0, 8191, -8192, 0, 8191, 0, 134242302, "isat_neg_e3"));
    vecs.push_back(mk(0, 8191, -8192, 0, 8191, 0, 49149, "isat_neg_e4"));
    vecs.push_back(mk(0, 8191, -8192, 0, 8191, 0, -134144004, "isat_neg_e5"));

    foreach (vecs[k]) begin
      drive(vecs[k].r, vecs[k].di, vecs[k].sp, vecs[k].p, vecs[k].i, vecs[k].d);
      check(vecs[k].name, vecs[k].exp);
    end

    // Output saturation at the negative rail; must hold there without wrapping.
    drive(1'b1, -8192, 8191, -8192, -8191, 0);
    check("osat_rst", 0);
    drive(1'b0, -8192, 8191, -8192, -8191, 0);
    drive(1'b0, -8192, 8191, -8192, -8191, 0);
    drive(1'b0, -8192, 8191, -8192, -8191, 0);
    check("osat_e3", -268402689);
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, -8192, 8191, -8192, -8191, 0);
      check("osat_hold", -268435456);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
